// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// fault cause codes and the accept-time fault classifier.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_RANGE    = 2'd2,
    CAUSE_ILLEGAL  = 2'd3
  } lsu_cause_e;

  // Highest-priority fault wins: illegal encoding, then alignment, then range.
  function automatic lsu_cause_e fault_cause(
    input logic       we,
    input logic [2:0] funct3,
    input logic [1:0] addr_lo,
    input logic       out_of_range
  );
    logic illegal;
    logic misalign;
    illegal  = we ? (funct3 > 3'd2)
                  : ((funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7));
    misalign = ((funct3[1:0] == 2'd1) && addr_lo[0]) ||
               ((funct3[1:0] == 2'd2) && (addr_lo != 2'd0));
    if (illegal) begin
      fault_cause = CAUSE_ILLEGAL;
    end else if (misalign) begin
      fault_cause = CAUSE_MISALIGN;
    end else if (out_of_range) begin
      fault_cause = CAUSE_RANGE;
    end else begin
      fault_cause = CAUSE_NONE;
    end
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load lane extract with sign/zero extension, and the
// store merge that replaces only the addressed byte/half of an old word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [4:0]  w_shamt;
  logic [31:0] w_lane;
  logic [31:0] w_mask;

  assign w_shamt = {i_addr_lo, 3'b000};
  assign w_lane  = i_rd_word >> w_shamt;

  always_comb begin
    o_load_data = 32'd0;
    case (i_funct3)
      F3_LB:   o_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_LH:   o_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_LW:   o_load_data = w_lane;
      F3_LBU:  o_load_data = {24'd0, w_lane[7:0]};
      F3_LHU:  o_load_data = {16'd0, w_lane[15:0]};
      default: o_load_data = 32'd0;
    endcase
  end

  // A full-word mask makes SW fall out of the same merge expression.
  always_comb begin
    w_mask = 32'd0;
    case (i_funct3)
      F3_SB:   w_mask = 32'h0000_00FF << w_shamt;
      F3_SH:   w_mask = 32'h0000_FFFF << w_shamt;
      F3_SW:   w_mask = 32'hFFFF_FFFF;
      default: w_mask = 32'd0;
    endcase
    o_store_word = (i_old_word & ~w_mask) | ((i_wdata << w_shamt) & w_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU request at a time, drives the word-wide
// data memory port and returns a single response (data or fault).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_cause,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  lsu_state_e        r_state;
  lsu_state_e        w_next_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_merge;
  logic [31:0]       r_rdata;
  logic              r_err;
  lsu_cause_e        r_cause;

  logic              w_accept;
  logic              w_out_of_range;
  lsu_cause_e        w_cause;
  logic [31:0]       w_load_data;
  logic [31:0]       w_store_word;

  assign w_accept       = req_valid && (r_state == S_IDLE);
  assign w_out_of_range = |req_addr[31:ADDR_W+2];
  assign w_cause        = fault_cause(req_we, req_funct3, req_addr[1:0], w_out_of_range);

  lsu_align u_align (
    .i_rd_word    (mem_RD),
    .i_old_word   (r_merge),
    .i_wdata      (r_wdata),
    .i_addr_lo    (r_addr[1:0]),
    .i_funct3     (r_funct3),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Sub-word stores detour through READ to fetch the word they merge into.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_cause != CAUSE_NONE) begin
            w_next_state = S_RESP;
          end else if (!req_we) begin
            w_next_state = S_READ;
          end else if (req_funct3 == F3_SW) begin
            w_next_state = S_WRITE;
          end else begin
            w_next_state = S_READ;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_READ:  w_next_state = r_we ? S_WRITE : S_RESP;
      S_WRITE: w_next_state = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_RESP;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Memory strobes decode from the state register so reset drops mem_WE at once.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_A      = 32'd0;
    mem_WD     = 32'd0;
    mem_WE     = 1'b0;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_READ: mem_A = {{(32-ADDR_W){1'b0}}, r_addr[ADDR_W+1:2]};
      S_WRITE: begin
        mem_A  = {{(32-ADDR_W){1'b0}}, r_addr[ADDR_W+1:2]};
        mem_WD = w_store_word;
        mem_WE = 1'b1;
      end
      S_RESP:  resp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_merge  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
      r_cause  <= CAUSE_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[ADDR_W+1:0];
            r_wdata  <= req_wdata;
            r_rdata  <= 32'd0;
            r_err    <= (w_cause != CAUSE_NONE);
            r_cause  <= w_cause;
          end
        end
        S_READ: begin
          if (r_we) begin
            r_merge <= mem_RD;
          end else begin
            r_rdata <= w_load_data;
          end
        end
        default: begin
          r_merge <= r_merge;
        end
      endcase
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign resp_cause = r_cause;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and a
// response scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  resp_cause;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  logic [31:0] mem [0:1023];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  cause;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          we_cnt;
  logic [31:0] we_a;
  logic [31:0] we_wd;
  logic [31:0] rd_a;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .resp_cause (resp_cause),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_WE     (mem_WE),
    .mem_RD     (mem_RD)
  );

  always @(posedge clk) begin
    if (mem_WE) mem[mem_A[9:0]] <= mem_WD;
  end
  assign mem_RD = mem[mem_A[9:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] e_rd, input logic e_err, input logic [1:0] e_cause,
                        input int e_lat, input int e_we, input int hold);
    exp_t e;
    int   lat;
    bit   seen;
    e = '{rdata: e_rd, err: e_err, cause: e_cause};
    sb_q.push_back(e);
    @(negedge clk);
    chk({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    we_cnt = 0; we_a = 32'd0; we_wd = 32'd0; rd_a = 32'd0; lat = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
      end else begin
        if (mem_WE) begin
          we_cnt++; we_a = mem_A; we_wd = mem_WD;
        end else begin
          rd_a = mem_A;
        end
        lat++;
      end
    end
    chk({tag, ":resp_seen"}, 32'(seen), 32'd1);
    chk({tag, ":latency"}, 32'(lat), 32'(e_lat));
    chk({tag, ":we_cycles"}, 32'(we_cnt), 32'(e_we));
    chk({tag, ":we_in_resp"}, 32'(mem_WE), 32'd0);
    e = sb_q.pop_front();
    chk({tag, ":rdata"}, resp_rdata, e.rdata);
    chk({tag, ":err"}, 32'(resp_err), 32'(e.err));
    chk({tag, ":cause"}, 32'(resp_cause), 32'(e.cause));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ":hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ":hold_rdata"}, resp_rdata, e.rdata);
      chk({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    resp_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst:resp_valid", 32'(resp_valid), 32'd0);
    chk("rst:resp_rdata", resp_rdata, 32'd0);
    chk("rst:resp_err", 32'(resp_err), 32'd0);
    chk("rst:resp_cause", 32'(resp_cause), 32'd0);
    chk("rst:mem_WE", 32'(mem_WE), 32'd0);
    chk("rst:mem_A", mem_A, 32'd0);
    chk("rst:mem_WD", mem_WD, 32'd0);
    #2 rst = 1'b0;

    // Basic word store and load.
    do_req("sw20", 1'b1, 3'd2, 32'h70, 32'h0000_0020, 32'd0, 1'b0, 2'd0, 1, 1, 0);
    chk("sw20:we_a", we_a, 32'd28);
    chk("sw20:we_wd", we_wd, 32'h0000_0020);
    do_req("lw20", 1'b0, 3'd2, 32'h70, 32'd0, 32'h0000_0020, 1'b0, 2'd0, 1, 0, 0);
    chk("lw20:rd_a", rd_a, 32'd28);

    // Read-modify-write byte store.
    do_req("sw_init", 1'b1, 3'd2, 32'h70, 32'h1122_3344, 32'd0, 1'b0, 2'd0, 1, 1, 0);
    do_req("sb71", 1'b1, 3'd0, 32'h71, 32'h0000_00AB, 32'd0, 1'b0, 2'd0, 2, 1, 0);
    chk("sb71:rd_a", rd_a, 32'd28);
    chk("sb71:we_a", we_a, 32'd28);
    chk("sb71:we_wd", we_wd, 32'h1122_AB44);
    do_req("lb71", 1'b0, 3'd0, 32'h71, 32'd0, 32'hFFFF_FFAB, 1'b0, 2'd0, 1, 0, 0);
    do_req("lbu71", 1'b0, 3'd4, 32'h71, 32'd0, 32'h0000_00AB, 1'b0, 2'd0, 1, 0, 0);
    do_req("lh72", 1'b0, 3'd1, 32'h72, 32'd0, 32'h0000_1122, 1'b0, 2'd0, 1, 0, 0);
    do_req("lb73", 1'b0, 3'd0, 32'h73, 32'd0, 32'h0000_0011, 1'b0, 2'd0, 1, 0, 0);
    do_req("lbu70", 1'b0, 3'd4, 32'h70, 32'd0, 32'h0000_0044, 1'b0, 2'd0, 1, 0, 0);

    // Half store with junk in the upper wdata bits.
    do_req("sh72", 1'b1, 3'd1, 32'h72, 32'hCAFE_8001, 32'd0, 1'b0, 2'd0, 2, 1, 0);
    chk("sh72:we_wd", we_wd, 32'h8001_AB44);
    do_req("lh72n", 1'b0, 3'd1, 32'h72, 32'd0, 32'hFFFF_8001, 1'b0, 2'd0, 1, 0, 0);
    do_req("lhu72", 1'b0, 3'd5, 32'h72, 32'd0, 32'h0000_8001, 1'b0, 2'd0, 1, 0, 0);

    // Last in-range word.
    do_req("sw_top", 1'b1, 3'd2, 32'hFFC, 32'h5A5A_5A5A, 32'd0, 1'b0, 2'd0, 1, 1, 0);
    chk("sw_top:we_a", we_a, 32'd1023);
    do_req("lw_top", 1'b0, 3'd2, 32'hFFC, 32'd0, 32'h5A5A_5A5A, 1'b0, 2'd0, 1, 0, 0);

    // Faults and their priority.
    do_req("lh_mis", 1'b0, 3'd1, 32'h73, 32'd0, 32'd0, 1'b1, 2'd1, 0, 0, 0);
    do_req("lw_f3", 1'b0, 3'd3, 32'h70, 32'd0, 32'd0, 1'b1, 2'd3, 0, 0, 0);
    do_req("sw_oor", 1'b1, 3'd2, 32'h1000, 32'hDEAD_BEEF, 32'd0, 1'b1, 2'd2, 0, 0, 0);
    chk("sw_oor:mem28", mem[28], 32'h8001_AB44);
    do_req("lw_mis_oor", 1'b0, 3'd2, 32'h1001, 32'd0, 32'd0, 1'b1, 2'd1, 0, 0, 0);
    do_req("ld_f7_oor", 1'b0, 3'd7, 32'h1003, 32'd0, 32'd0, 1'b1, 2'd3, 0, 0, 0);
    do_req("st_f3", 1'b1, 3'd3, 32'h70, 32'h1234_5678, 32'd0, 1'b1, 2'd3, 0, 0, 0);
    do_req("lbu_oor", 1'b0, 3'd4, 32'h1000, 32'd0, 32'd0, 1'b1, 2'd2, 0, 0, 0);
    chk("faults:mem28", mem[28], 32'h8001_AB44);

    // Backpressured response, then an immediate follow-up request.
    do_req("lw_hold", 1'b0, 3'd2, 32'h70, 32'd0, 32'h8001_AB44, 1'b0, 2'd0, 1, 0, 3);
    do_req("lw_b2b", 1'b0, 3'd2, 32'hFFC, 32'd0, 32'h5A5A_5A5A, 1'b0, 2'd0, 1, 0, 0);

    // Reset while an SH sits in READ.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h70; req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    @(negedge clk);
    chk("rst_rd:mem_A", mem_A, 32'd28);
    chk("rst_rd:we_before", 32'(mem_WE), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("rst_rd:we_async", 32'(mem_WE), 32'd0);
    chk("rst_rd:resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rd:req_ready", 32'(req_ready), 32'd1);
    chk("rst_rd:resp_valid_after", 32'(resp_valid), 32'd0);
    chk("rst_rd:mem28", mem[28], 32'h8001_AB44);

    // Reset while an SW sits in WRITE: the write must not land.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h70; req_wdata = 32'h9999_9999;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    chk("rst_wr:we_before", 32'(mem_WE), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_wr:we_async", 32'(mem_WE), 32'd0);
    chk("rst_wr:mem_A", mem_A, 32'd0);
    chk("rst_wr:mem_WD", mem_WD, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wr:mem28", mem[28], 32'h8001_AB44);
    chk("rst_wr:req_ready", 32'(req_ready), 32'd1);
    chk("rst_wr:resp_valid", 32'(resp_valid), 32'd0);

    do_req("lw_post", 1'b0, 3'd2, 32'h70, 32'd0, 32'h8001_AB44, 1'b0, 2'd0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
